hazard_stall_ctrl: RTL

- Stall, bubble and flush controller for the 5-stage pipeline (F, D, X, M, W).
- It is the complement of the forwarding selectors. Where forwarding cannot resolve a dependency, this block freezes upstream stages and injects NOPs.
- Covered cases:
  - load-use hazards;
  - multi-cycle mult/div occupancy of X;
  - taken branches and jumps resolved in X.
- Holds a small state machine around the multdiv unit handshake.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/md_seq.sv | 94 +++++++++
 rtl/hazard_stall_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard controller and its multdiv
// sequencer: sequencer state encoding, the NOP word and the instruction
// opcode / ALU-op constants used to decode D and X stage instructions.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2
  } md_state_t;

  localparam logic [31:0] NOP_INSN = 32'd0;

  // Primary opcodes (insn[31:27])
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // R-type ALU ops that go to the multdiv unit
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

endpackage

// File: rtl/md_seq.sv
// Multdiv handshake sequencer. Issues a one-cycle start pulse when a mul/div
// reaches X, then holds X busy until md_ready or until MD_TIMEOUT wait cycles
// elapse, in which case the sticky md_timeout flag is set and X is released.
// Ports:
//   clock, reset            pipeline clock, async active-high reset
//   dx_is_mult, dx_is_div   mul/div instruction sitting in X
//   branch_taken            taken control transfer in X (blocks a start)
//   md_ready                multdiv result-valid pulse
//   md_busy                 multdiv occupies X (MD_START or MD_WAIT)
//   md_release              md_ready accepted this cycle (X may advance)
//   md_ctrl_mult/div        start pulses
//   md_timeout              sticky timeout flag
module md_seq
  import pipe_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic dx_is_mult,
  input  logic dx_is_div,
  input  logic branch_taken,
  input  logic md_ready,
  output logic md_busy,
  output logic md_release,
  output logic md_ctrl_mult,
  output logic md_ctrl_div,
  output logic md_timeout
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MD_TIMEOUT);

  md_state_t        state, state_nx;
  logic             op_mult, op_mult_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             timeout_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_mult    <= 1'b0;
      cnt        <= '0;
      md_timeout <= 1'b0;
    end else begin
      state      <= state_nx;
      op_mult    <= op_mult_nx;
      cnt        <= cnt_nx;
      md_timeout <= timeout_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    op_mult_nx   = op_mult;
    cnt_nx       = cnt;
    timeout_nx   = md_timeout;
    md_busy      = 1'b0;
    md_release   = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    cnt_inc      = (cnt == CNT_LIM) ? cnt : cnt + 1'b1;

    case (state)
      IDLE: begin
        if ((dx_is_mult || dx_is_div) && !branch_taken) begin
          state_nx   = MD_START;
          op_mult_nx = dx_is_mult;
        end
      end
      MD_START: begin
        md_busy      = 1'b1;
        md_ctrl_mult = op_mult;
        md_ctrl_div  = !op_mult;
        cnt_nx       = '0;
        state_nx     = MD_WAIT;
      end
      MD_WAIT: begin
        md_busy = 1'b1;
        cnt_nx  = cnt_inc;
        if (md_ready) begin
          md_release = 1'b1;
          state_nx   = IDLE;
        end else if (cnt_inc == CNT_LIM) begin
          // compare the incremented value so exactly MD_TIMEOUT wait cycles elapse
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall / bubble / flush controller for the 5-stage pipeline. Covers the
// hazards forwarding cannot resolve: load-use, multdiv occupancy of X, and
// taken control transfers resolved in X. Priority: multdiv > branch > load-use.
// Ports:
//   clock, reset                   pipeline clock, async active-high reset
//   fd_rs, fd_rt, fd_use_rs/rt     D-stage source registers and use flags
//   fd_is_store                    D instruction is sw (rt is store data)
//   dx_rd, dx_is_load/mult/div     X-stage destination and op class
//   branch_taken                   taken bne/blt/j/jal/jr/bex in X
//   md_ready                       multdiv result-valid pulse
//   md_ctrl_mult/div               multdiv start pulses
//   stall_pc, stall_fd, stall_dx   hold PC / F/D / D/X
//   bubble_dx, bubble_xm, flush_fd NOP injection into D/X, X/M, F/D
//   md_busy, md_timeout            multdiv occupancy and sticky timeout
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] fd_rs,
  input  logic [4:0] fd_rt,
  input  logic       fd_use_rs,
  input  logic       fd_use_rt,
  input  logic       fd_is_store,
  input  logic [4:0] dx_rd,
  input  logic       dx_is_load,
  input  logic       dx_is_mult,
  input  logic       dx_is_div,
  input  logic       branch_taken,
  input  logic       md_ready,
  output logic       md_ctrl_mult,
  output logic       md_ctrl_div,
  output logic       stall_pc,
  output logic       stall_fd,
  output logic       stall_dx,
  output logic       bubble_dx,
  output logic       bubble_xm,
  output logic       flush_fd,
  output logic       md_busy,
  output logic       md_timeout
);

  logic md_release;
  logic load_use;
  logic md_hold;

  md_seq #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clock        (clock),
    .reset        (reset),
    .dx_is_mult   (dx_is_mult),
    .dx_is_div    (dx_is_div),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .md_busy      (md_busy),
    .md_release   (md_release),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_timeout   (md_timeout)
  );

  // Store data (rt of sw) is forwarded from M, so only address/ALU reads stall.
  assign load_use = dx_is_load && (dx_rd != 5'd0) &&
                    ((fd_use_rs && (fd_rs == dx_rd)) ||
                     (fd_use_rt && (fd_rt == dx_rd) && !fd_is_store));

  assign md_hold = md_busy && !md_release;

  always_comb begin
    stall_pc  = 1'b0;
    stall_fd  = 1'b0;
    stall_dx  = 1'b0;
    bubble_dx = 1'b0;
    bubble_xm = 1'b0;
    flush_fd  = 1'b0;

    if (reset) begin
      // keep every hazard output quiet while reset is held
    end else if (md_busy) begin
      stall_pc  = md_hold;
      stall_fd  = md_hold;
      stall_dx  = md_hold;
      bubble_xm = md_hold;
    end else if (branch_taken) begin
      flush_fd  = 1'b1;
      bubble_dx = 1'b1;
    end else if (load_use) begin
      stall_pc  = 1'b1;
      stall_fd  = 1'b1;
      bubble_dx = 1'b1;
    end
  end

endmodule
